// File: rtl/hi_lo_mac_unit.sv
// HI/LO register pair with an iterative radix-2 multiply / multiply-accumulate engine (HILO_EARLY_TERM_EN: stop early once the remaining multiplier bits are zero).
// Latency: MTHI/MTLO write at the accept edge; multiply ops take WIDTH (or fewer, early-term) MUL edges plus one FINAL edge.
// Backpressure: Start is ignored while Busy=1; the hazard unit stalls on Busy.
module hi_lo_mac_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiReadData,
  output logic [WIDTH-1:0] LoReadData
);

  typedef enum logic [1:0] {IDLE, MUL, FINAL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   hi, lo, mplier;
  logic [2*WIDTH-1:0] mcand, product;
  logic [1:0]         kind;
  logic               sign;
  logic [CNT_W-1:0]   cnt;
  logic               busy, done;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_prod, p, result;
  logic               last_step;

  always_comb begin
    signed_op = ~Op[0];
    // Negating the most negative value yields 2^(W-1), which is exact as a W-bit unsigned magnitude.
    a_mag = (signed_op && A[WIDTH-1]) ? -A : A;
    b_mag = (signed_op && B[WIDTH-1]) ? -B : B;
  end

  always_comb begin
    step_prod = product + (mplier[0] ? mcand : '0);
`ifdef HILO_EARLY_TERM_EN
    last_step = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
    last_step = (cnt == CNT_W'(WIDTH - 1));
`endif
  end

  always_comb begin
    p = sign ? -product : product;
    case (kind)
      2'b00:   result = p;
      2'b01:   result = {hi, lo} + p;
      default: result = {hi, lo} - p;
    endcase
  end

  always_ff @(negedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      mplier  <= '0;
      mcand   <= '0;
      product <= '0;
      kind    <= 2'b00;
      sign    <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (Op[2:1] == 2'b11) begin
              if (Op[0]) lo <= A;
              else       hi <= A;
              done <= 1'b1;
            end else begin
              kind    <= Op[2:1];
              mcand   <= {{WIDTH{1'b0}}, a_mag};
              mplier  <= b_mag;
              sign    <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
              product <= '0;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= MUL;
            end
          end
        end
        MUL: begin
          product <= step_prod;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          cnt     <= cnt + 1'b1;
          if (last_step) state <= FINAL;
        end
        FINAL: begin
          {hi, lo} <= result;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy       = busy;
  assign Done       = done;
  assign HiReadData = hi;
  assign LoReadData = lo;

endmodule

// File: tb/tb_hi_lo_mac_unit.sv
// Directed, table-driven bench for hi_lo_mac_unit (state updates on the falling edge; bench drives and samples on the rising edge).
module tb_hi_lo_mac_unit;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_MADD = 3'b010,
                         OP_MADDU = 3'b011, OP_MSUB = 3'b100, OP_MSUBU = 3'b101,
                         OP_MTHI = 3'b110, OP_MTLO = 3'b111;

  logic         Clk = 1'b1;
  logic         Reset, Start;
  logic [2:0]   Op;
  logic [W-1:0] A, B;
  logic         Busy, Done;
  logic [W-1:0] HiReadData, LoReadData;

  int total = 0;
  int bad   = 0;

  hi_lo_mac_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .HiReadData(HiReadData), .LoReadData(LoReadData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int bl;
    if (op[2:1] == 2'b11) return 0;
    mag = (!op[0] && b[W-1]) ? -b : b;
    bl = 0;
    for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
`ifdef HILO_EARLY_TERM_EN
    return ((bl < 1) ? 1 : bl) + 1;
`else
    return W + 1;
`endif
  endfunction

  // Called at a rising edge; returns at the rising edge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    @(posedge Clk);
    Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  // Counts falling edges until Done is seen; bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int lat, output int busy_cyc, output bit held);
    logic [W-1:0] h0, l0;
    h0 = HiReadData; l0 = LoReadData;
    lat = 0; busy_cyc = 0; held = 1'b1;
    while (!Done && lat < 100) begin
      if (Busy) busy_cyc++;
      if (HiReadData !== h0 || LoReadData !== l0) held = 1'b0;
      @(negedge Clk);
      lat++;
      @(posedge Clk);
    end
  endtask

  initial begin
    int lat, bcyc, el, ndone;
    bit held;
    logic [W-1:0] hsave;

    vecs[0]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{OP_MTLO,  32'h12345678, 32'h0,        32'hDEADBEEF, 32'h12345678};
    vecs[2]  = '{OP_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[4]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5]  = '{OP_MTHI,  32'h0,        32'h0,        32'h00000000, 32'h00000000};
    vecs[6]  = '{OP_MTLO,  32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF};
    vecs[7]  = '{OP_MADDU, 32'h1,        32'h1,        32'h00000001, 32'h00000000};
    vecs[8]  = '{OP_MTHI,  32'h0,        32'h0,        32'h00000000, 32'h00000000};
    vecs[9]  = '{OP_MSUB,  32'h1,        32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{OP_MADD,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[11] = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[12] = '{OP_MSUBU, 32'h2,        32'h3,        32'hC0000000, 32'h7FFFFFFA};
    vecs[13] = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vecs[14] = '{OP_MULTU, 32'h5,        32'h1,        32'h00000000, 32'h00000005};
    vecs[15] = '{OP_MULTU, 32'h5,        32'h0,        32'h00000000, 32'h00000000};
    vecs[16] = '{OP_MULTU, 32'h1,        32'h80000000, 32'h00000000, 32'h80000000};
    vecs[17] = '{OP_MADD,  32'h2,        32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFE};

    Reset = 1'b0; Start = 1'b0; Op = 3'b000; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    Reset = 1'b1;
    chk("reset_hi",   64'(HiReadData), 64'h0);
    chk("reset_lo",   64'(LoReadData), 64'h0);
    chk("reset_busy", 64'(Busy), 64'h0);
    chk("reset_done", 64'(Done), 64'h0);

    // Each vector is issued on the Done cycle of the previous one, exercising back-to-back acceptance.
    for (int i = 0; i < 18; i++) begin
      el = exp_lat(vecs[i].op, vecs[i].b);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcyc, held);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(el));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'(el));
      chk($sformatf("v%0d_busy_at_done", i), 64'(Busy), 64'h0);
      chk($sformatf("v%0d_hilo", i), {HiReadData, LoReadData}, {vecs[i].hi, vecs[i].lo});
      if (vecs[i].op[2:1] != 2'b11)
        chk($sformatf("v%0d_hilo_held", i), 64'(held), 64'h1);
    end

    @(negedge Clk); @(posedge Clk);
    chk("done_one_cycle", 64'(Done), 64'h0);

    // Start pulsed mid-operation must be ignored.
    issue(OP_MULT, 32'h3, 32'h40000004);
    repeat (4) begin @(negedge Clk); @(posedge Clk); end
    Start = 1'b1; Op = OP_MTHI; A = 32'hFFFFFFFF; B = 32'h5;
    @(negedge Clk); @(posedge Clk);
    Start = 1'b0;
    wait_done(lat, bcyc, held);
    chk("ignored_start_latency", 64'(lat + 5), 64'(exp_lat(OP_MULT, 32'h40000004)));
    chk("ignored_start_hilo", {HiReadData, LoReadData}, 64'h00000000_C000000C);
    hsave = HiReadData;
    @(negedge Clk); @(posedge Clk);
    chk("ignored_start_no_extra_done", 64'(Done), 64'h0);
    chk("ignored_start_hi_kept", 64'(HiReadData), 64'(hsave));

    // Reset during MUL step 10 aborts the operation.
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) begin @(negedge Clk); @(posedge Clk); end
    chk("pre_abort_busy", 64'(Busy), 64'h1);
    Reset = 1'b0;
    @(negedge Clk); @(posedge Clk);
    Reset = 1'b1;
    chk("abort_hilo", {HiReadData, LoReadData}, 64'h0);
    chk("abort_busy", 64'(Busy), 64'h0);
    ndone = 0;
    repeat (40) begin
      @(negedge Clk); @(posedge Clk);
      if (Done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'h0);
    chk("abort_hilo_stays", {HiReadData, LoReadData}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
